// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared encodings for the multi-cycle divide controller
// Purpose: FSM state encoding and ready/start level names used by div_ctrl.
// Ports:   none (package).
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BYZERO  = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
// Purpose: trial-subtract the divisor from the top window of the working
//          register and shift in one quotient bit.
// Ports:   dividend      - current working register (2*DATA_W+1 bits)
//          divisor       - divisor magnitude
//          dividend_next - working register after this iteration
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]  dividend,
  input  logic [DATA_W-1:0]  divisor,
  output logic [2*DATA_W:0]  dividend_next
);

  // Two extra bits: the window can reach 2*divisor-1, which needs DATA_W+1
  // bits, so the borrow has to land one bit higher still.
  logic [DATA_W+1:0] diff;
  logic              negative;

  assign diff = {1'b0, dividend[2*DATA_W:DATA_W]} - {2'b00, divisor};

  // A successful subtraction always leaves a value below the divisor, so the
  // top two bits are both zero exactly when the result is non-negative.
  assign negative = |diff[DATA_W+1:DATA_W];

  assign dividend_next = negative ? {dividend[2*DATA_W-1:0], 1'b0}
                                  : {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU controller for the EX stage
// Purpose: sequence a DATA_W-iteration restoring divide, apply sign
//          correction, return {remainder, quotient} and stall the pipe.
// Ports:   clk, rst       - clock, asynchronous active-high reset
//          signed_div_i   - 1 = DIV, 0 = DIVU
//          opdata1_i/2_i  - dividend / divisor
//          start_i        - request, held until ready_o
//          annul_i        - abort current or pending operation
//          result_o       - {remainder (HI), quotient (LO)}
//          ready_o        - result valid
//          stallreq_o     - pipeline stall request
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  div_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2*DATA_W:0]   dividend_r, dividend_nxt, dividend_step;
  logic [DATA_W-1:0]   divisor_r, divisor_nxt;
  logic                neg1_r, neg1_nxt, neg2_r, neg2_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic [DATA_W-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // neg1_r/neg2_r already include the signed qualifier, so the corrections
  // below are inactive for DIVU without a separate signed flag.
  assign quo_raw = dividend_r[DATA_W-1:0];
  assign rem_raw = dividend_r[2*DATA_W:DATA_W+1];
  assign quo_fix = (neg1_r ^ neg2_r) ? -quo_raw : quo_raw;
  assign rem_fix = neg1_r ? -rem_raw : rem_raw;

  assign stallreq_o = (start_i == DIV_START) & (ready_o == DIV_RESULT_NOT_READY) & ~annul_i;

  div_step #(.DATA_W(DATA_W)) u_step (
    .dividend      (dividend_r),
    .divisor       (divisor_r),
    .dividend_next (dividend_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DIV_FREE;
      cnt        <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      neg1_r     <= 1'b0;
      neg2_r     <= 1'b0;
      result_o   <= '0;
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dividend_r <= dividend_nxt;
      divisor_r  <= divisor_nxt;
      neg1_r     <= neg1_nxt;
      neg2_r     <= neg2_nxt;
      result_o   <= result_nxt;
      ready_o    <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dividend_nxt = dividend_r;
    divisor_nxt  = divisor_r;
    neg1_nxt     = neg1_r;
    neg2_nxt     = neg2_r;
    result_nxt   = result_o;
    ready_nxt    = ready_o;
    case (state)
      DIV_FREE: begin
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DIV_BYZERO;
          end else begin
            state_nxt    = DIV_ON;
            cnt_nxt      = '0;
            dividend_nxt = {{DATA_W{1'b0}}, op1_mag, 1'b0};
            divisor_nxt  = op2_mag;
            neg1_nxt     = op1_neg;
            neg2_nxt     = op2_neg;
          end
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          state_nxt = DIV_FREE;
        end else begin
          state_nxt  = DIV_END;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_nxt = DIV_FREE;
        end else if (cnt == CNT_DONE) begin
          state_nxt  = DIV_END;
          result_nxt = {rem_fix, quo_fix};
          ready_nxt  = DIV_RESULT_READY;
        end else begin
          dividend_nxt = dividend_step;
          cnt_nxt      = cnt + CNT_W'(1);
        end
      end
      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_nxt  = DIV_FREE;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_nxt = DIV_FREE;
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl
module tb_div_ctrl;

  localparam int DATA_W = 32;

  logic                clk;
  logic                rst;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise start with the given operands and count edges until ready_o.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic stall_ok);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    edges        = 0;
    stall_ok     = 1'b1;
    #1;
    while (ready_o !== 1'b1 && edges < 100) begin
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
      tick();
      edges++;
    end
  endtask

  int   edges;
  logic stall_ok;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 34};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 34};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'h80000000,   32'h00000001, 32'h7FFFFFFF, 34};
    vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 34};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 34};
    vecs[6]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 32'h00000002, 34};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 34};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'h00000000, 32'h00000005, 34};
    vecs[9]  = '{1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF,   32'h00000000, 32'hFFFFFFFE, 34};
    vecs[10] = '{1'b0, 32'd9,          32'd3,          32'h00000003, 32'h00000000, 34};
    vecs[11] = '{1'b0, 32'hDEADBEEF,   32'h00010000,   32'h0000DEAD, 32'h0000BEEF, 34};
    vecs[12] = '{1'b0, 32'd1234,       32'd0,          32'h00000000, 32'h00000000, 2};
    vecs[13] = '{1'b1, 32'hFFFFFFFF,   32'd0,          32'h00000000, 32'h00000000, 2};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check("reset_ready", ready_o, 0);
    check("reset_result", result_o, 0);
    check("reset_stall", stallreq_o, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_ready", ready_o, 0);

    for (int i = 0; i < 14; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, edges, stall_ok);
      check($sformatf("v%0d_latency", i), edges, vecs[i].lat);
      check($sformatf("v%0d_result", i), result_o, {vecs[i].r, vecs[i].q});
      check($sformatf("v%0d_stall_busy", i), stall_ok, 1);
      check($sformatf("v%0d_stall_done", i), stallreq_o, 0);
      start_i = 1'b0;
      tick();
      check($sformatf("v%0d_drop_ready", i), ready_o, 0);
      check($sformatf("v%0d_drop_result", i), result_o, 0);
    end

    // Annul at edge 10, then restart immediately from FREE with 9/3.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (9) tick();
    check("annul_pre_ready", ready_o, 0);
    annul_i = 1'b1;
    #1;
    check("annul_stall", stallreq_o, 0);
    tick();
    check("annul_ready", ready_o, 0);
    run_div(1'b0, 32'd9, 32'd3, edges, stall_ok);
    check("annul_restart_latency", edges, 34);
    check("annul_restart_result", result_o, {32'd0, 32'd3});
    annul_i = 1'b1;
    #1;
    check("annul_end_stall", stallreq_o, 0);
    tick();
    check("annul_end_ready", ready_o, 0);
    check("annul_end_result", result_o, 0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Signed wrap-around case, then hold start in END for five cycles.
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, edges, stall_ok);
    check("wrap_latency", edges, 34);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold%0d_ready", k), ready_o, 1);
      check($sformatf("hold%0d_result", k), result_o, {32'd0, 32'h80000000});
    end
    start_i = 1'b0;
    tick();
    check("hold_release_ready", ready_o, 0);

    // Asynchronous reset while ON with cnt=15, then a fresh 9/3.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (16) tick();
    #2;
    rst     = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_on_ready", ready_o, 0);
    check("rst_on_result", result_o, 0);
    tick();
    rst = 1'b0;
    tick();
    run_div(1'b0, 32'd9, 32'd3, edges, stall_ok);
    check("rst_restart_latency", edges, 34);
    check("rst_restart_result", result_o, {32'd0, 32'd3});

    // Asynchronous reset in END clears the held result without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("rst_end_ready", ready_o, 0);
    check("rst_end_result", result_o, 0);
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", ready_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
